// File: rtl/hack_seq_ctrl_pkg.sv
// Shared types for the Hack sequencer: FSM states and the instruction word layout.
package hack_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_RD,
    S_EXEC,
    S_MEM_WR,
    S_PCUPD
  } state_t;

  // For A-instructions (ci=0) the low 15 bits are the literal; rsvd is ignored.
  typedef struct packed {
    logic       ci;
    logic [1:0] rsvd;
    logic       a;
    logic [5:0] cmp;
    logic       d1;
    logic       d2;
    logic       d3;
    logic [2:0] jmp;
  } instr_t;

endpackage

// File: rtl/hack_seq_ctrl_jump.sv
// Jump condition from the three Hack jump bits and the latched ALU flags.
module hack_seq_ctrl_jump (
  input  logic [2:0] j,
  input  logic       zr,
  input  logic       ng,
  output logic       jump
);

  assign jump = (j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr);

endmodule

// File: rtl/hack_seq_ctrl.sv
// Multi-cycle Hack CPU sequencer: fetches over a ROM handshake, drives an external
// combinational ALU, owns A/D/PC and performs M accesses over a data-memory handshake.
module hack_seq_ctrl
  import hack_seq_ctrl_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int WORD_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [WORD_W-1:0] rom_data,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] alu_x,
  output logic [WORD_W-1:0] alu_y,
  output logic [5:0]        alu_ctl,
  input  logic [WORD_W-1:0] alu_out,
  input  logic              alu_zr,
  input  logic              alu_ng,
  output logic [ADDR_W-1:0] pc
);

  state_t            state;
  instr_t            ir;
  logic              run;
  logic [WORD_W-1:0] a_reg, d_reg, m_lat, res;
  logic [ADDR_W-1:0] a_q;
  logic              zr_q, ng_q, jump;

  hack_seq_ctrl_jump u_jump (
    .j    (ir.jmp),
    .zr   (zr_q),
    .ng   (ng_q),
    .jump (jump)
  );

  // run holds the requests low while reset is asserted; acks seen then are dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_FETCH;
      run   <= 1'b0;
      ir    <= '0;
      pc    <= '0;
      a_reg <= '0;
      d_reg <= '0;
      a_q   <= '0;
      m_lat <= '0;
      res   <= '0;
      zr_q  <= 1'b0;
      ng_q  <= 1'b0;
    end else begin
      run <= 1'b1;
      unique case (state)
        S_FETCH: if (run && rom_ack) begin
          ir    <= instr_t'(rom_data);
          state <= S_DECODE;
        end
        S_DECODE: if (!ir.ci) begin
          a_reg <= WORD_W'(ir[ADDR_W-1:0]);
          pc    <= pc + ADDR_W'(1);
          state <= S_FETCH;
        end else begin
          a_q   <= a_reg[ADDR_W-1:0];
          state <= ir.a ? S_MEM_RD : S_EXEC;
        end
        S_MEM_RD: if (mem_ack) begin
          m_lat <= mem_rdata;
          state <= S_EXEC;
        end
        S_EXEC: begin
          res  <= alu_out;
          zr_q <= alu_zr;
          ng_q <= alu_ng;
          if (ir.d1) a_reg <= alu_out;
          if (ir.d2) d_reg <= alu_out;
          state <= ir.d3 ? S_MEM_WR : S_PCUPD;
        end
        S_MEM_WR: if (mem_ack) state <= S_PCUPD;
        S_PCUPD: begin
          // Target is A as it was before this instruction, even for AM=... forms.
          pc    <= jump ? a_q : pc + ADDR_W'(1);
          state <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  assign rom_req    = run && (state == S_FETCH);
  assign rom_addr   = pc;
  assign mem_rd_req = (state == S_MEM_RD);
  assign mem_wr_req = (state == S_MEM_WR);
  assign mem_addr   = a_q;
  assign mem_wdata  = res;
  assign alu_x      = d_reg;
  assign alu_y      = ir.a ? m_lat : a_reg;
  assign alu_ctl    = ir.cmp;

endmodule

// File: tb/tb_hack_seq_ctrl.sv
// Directed bench for hack_seq_ctrl with ROM/RAM responders and a reference Hack ALU.
module tb_hack_seq_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rom_req, rom_ack;
  logic [14:0] rom_addr, mem_addr, pc;
  logic [15:0] rom_data, mem_wdata, mem_rdata;
  logic        mem_rd_req, mem_wr_req, mem_ack;
  logic [15:0] alu_x, alu_y, alu_out;
  logic [5:0]  alu_ctl;
  logic        alu_zr, alu_ng;

  logic [15:0] rom [0:32767];
  logic [15:0] ram [0:32767];

  int          mem_wait = 0;
  logic        mem_ack_force = 1'b0;
  int          mem_cnt = 0;
  int          wr_count = 0;
  int          rd_cycles = 0;
  logic [14:0] last_waddr = '0;
  logic [15:0] last_wdata = '0;
  int          passes = 0;
  int          fails = 0;
  int          checks = 0;
  int          hi;

  always #5 clock = ~clock;

  hack_seq_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .rom_req    (rom_req),
    .rom_addr   (rom_addr),
    .rom_ack    (rom_ack),
    .rom_data   (rom_data),
    .mem_rd_req (mem_rd_req),
    .mem_wr_req (mem_wr_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_ctl    (alu_ctl),
    .alu_out    (alu_out),
    .alu_zr     (alu_zr),
    .alu_ng     (alu_ng),
    .pc         (pc)
  );

  // Zero-wait ROM; RAM acks after mem_wait deferred cycles.
  assign rom_ack   = rom_req;
  assign rom_data  = rom[rom_addr];
  assign mem_rdata = ram[mem_addr];
  assign mem_ack   = mem_ack_force | ((mem_rd_req | mem_wr_req) && (mem_cnt >= mem_wait));

  always_comb begin : alu_model
    logic [15:0] x, y, o;
    x = alu_ctl[5] ? 16'h0000 : alu_x;
    if (alu_ctl[4]) x = ~x;
    y = alu_ctl[3] ? 16'h0000 : alu_y;
    if (alu_ctl[2]) y = ~y;
    o = alu_ctl[1] ? (x + y) : (x & y);
    if (alu_ctl[0]) o = ~o;
    alu_out = o;
    alu_zr  = (o == 16'h0000);
    alu_ng  = o[15];
  end

  always @(posedge clock) begin
    if (reset) begin
      mem_cnt   <= 0;
      wr_count  <= 0;
      rd_cycles <= 0;
    end else begin
      if ((mem_rd_req | mem_wr_req) && !mem_ack) mem_cnt <= mem_cnt + 1;
      else mem_cnt <= 0;
      if (mem_wr_req && mem_ack) begin
        wr_count   <= wr_count + 1;
        last_waddr <= mem_addr;
        last_wdata <= mem_wdata;
      end
      if (mem_rd_req) rd_cycles <= rd_cycles + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32768; i++) begin
      rom[i] = 16'h0000;
      ram[i] = 16'h0000;
    end
  endtask

  task automatic restart();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // 1: @5 ; D=A
    clear_mem();
    rom[0] = 16'h0005;
    rom[1] = 16'hEC10;
    reset = 1'b1;
    step(2);
    chk("rst_rom_req", 32'(rom_req), 0);
    chk("rst_mem_rd_req", 32'(mem_rd_req), 0);
    chk("rst_mem_wr_req", 32'(mem_wr_req), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_alu_x", 32'(alu_x), 0);
    chk("rst_alu_y", 32'(alu_y), 0);
    chk("rst_alu_ctl", 32'(alu_ctl), 0);
    reset = 1'b0;
    step(1);
    chk("t1_rom_req_rise", 32'(rom_req), 1);
    chk("t1_rom_addr", 32'(rom_addr), 0);
    step(6);
    chk("t1_pc", 32'(pc), 2);
    chk("t1_D", 32'(alu_x), 5);
    chk("t1_A", 32'(alu_y), 5);

    // 2a: D=1 ; D=D-1;JGT -> D=0, no jump
    clear_mem();
    rom[0] = 16'h0001;
    rom[1] = 16'hEC10;
    rom[2] = 16'hE391;
    restart();
    step(11);
    chk("t2a_pc", 32'(pc), 3);
    chk("t2a_D", 32'(alu_x), 0);
    chk("t2a_ctl", 32'(alu_ctl), 'h0E);

    // 2b: D=2 ; @20 ; D=D-1;JGT -> D=1 is positive, jumps to 20
    clear_mem();
    rom[0] = 16'h0002;
    rom[1] = 16'hEC10;
    rom[2] = 16'h0014;
    rom[3] = 16'hE391;
    restart();
    step(13);
    chk("t2b_pc", 32'(pc), 20);
    chk("t2b_D", 32'(alu_x), 1);

    // 3: D=7 ; @100 ; M=D
    clear_mem();
    rom[0] = 16'h0007;
    rom[1] = 16'hEC10;
    rom[2] = 16'h0064;
    rom[3] = 16'hE308;
    restart();
    step(12);
    chk("t3_wr_req", 32'(mem_wr_req), 1);
    chk("t3_mem_addr", 32'(mem_addr), 100);
    chk("t3_wdata", 32'(mem_wdata), 7);
    step(2);
    chk("t3_wr_count", 32'(wr_count), 1);
    chk("t3_waddr", 32'(last_waddr), 100);
    chk("t3_wdata_acc", 32'(last_wdata), 7);
    chk("t3_no_rd", 32'(rd_cycles), 0);
    chk("t3_pc", 32'(pc), 4);

    // 4: @3 ; D=M with three deferred acks
    clear_mem();
    ram[3] = 16'h1234;
    rom[0] = 16'h0003;
    rom[1] = 16'hFC10;
    mem_wait = 3;
    restart();
    step(4);
    hi = 0;
    for (int k = 0; k < 6; k++) begin
      step(1);
      if (rom_req) hi++;
    end
    chk("t4_rom_req_low", 32'(hi), 0);
    step(1);
    chk("t4_pc", 32'(pc), 2);
    chk("t4_D", 32'(alu_x), 'h1234);
    chk("t4_rd_cycles", 32'(rd_cycles), 4);
    chk("t4_rom_req_back", 32'(rom_req), 1);
    mem_wait = 0;

    // 5: @42 ; 0;JMP -> 42 ; @0x7FFF ; 0;JMP -> 0x7FFF ; @5 wraps pc to 0
    clear_mem();
    rom[0]     = 16'h002A;
    rom[1]     = 16'hEA87;
    rom[42]    = 16'h7FFF;
    rom[43]    = 16'hEA87;
    rom[32767] = 16'h0005;
    restart();
    step(7);
    chk("t5_jmp42", 32'(pc), 42);
    step(6);
    chk("t5_jmp7fff", 32'(pc), 'h7FFF);
    step(2);
    chk("t5_wrap_pc", 32'(pc), 0);
    chk("t5_wrap_A", 32'(alu_y), 5);
    chk("t5_wrap_addr", 32'(rom_addr), 0);

    // 6: reset while M=D waits for its ack; late ack afterwards
    clear_mem();
    rom[0] = 16'h0007;
    rom[1] = 16'hEC10;
    rom[2] = 16'h0064;
    rom[3] = 16'hE308;
    mem_wait = 1000;
    restart();
    step(12);
    chk("t6_wr_req_wait", 32'(mem_wr_req), 1);
    step(1);
    reset = 1'b1;
    step(1);
    chk("t6_wr_req_drop", 32'(mem_wr_req), 0);
    chk("t6_rom_req_rst", 32'(rom_req), 0);
    chk("t6_pc", 32'(pc), 0);
    chk("t6_D", 32'(alu_x), 0);
    chk("t6_A", 32'(alu_y), 0);
    reset = 1'b0;
    mem_ack_force = 1'b1;
    step(1);
    mem_ack_force = 1'b0;
    mem_wait = 0;
    chk("t6_late_ack_wr", 32'(wr_count), 0);
    chk("t6_refetch_req", 32'(rom_req), 1);
    chk("t6_refetch_addr", 32'(rom_addr), 0);
    chk("t6_no_wr_req", 32'(mem_wr_req), 0);
    step(13);
    chk("t6_rerun_wr", 32'(wr_count), 1);
    chk("t6_rerun_data", 32'(last_wdata), 7);
    chk("t6_rerun_pc", 32'(pc), 4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
